fb_bias_add: RTL and testbench

FB_BIAS_ADD -- requirements
Module: fb_bias_add

---
 rtl/fb_bias_add.sv | 135 +++++++++++++
 tb/tb_fb_bias_add.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fb_bias_add.sv
// Per-channel bias add for a MAC frame: (in_data + coef) >>> SHIFT, saturated to 16 bits.
// Optional macro FB_BIAS_RELU_EN clamps negative results to zero before they are registered.
module fb_bias_add #(
  parameter int WIDTH_A = 12,
  parameter int NUM_CH  = 120,
  parameter int ACC_W   = 24,
  parameter int SHIFT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W-1:0]     in_data,
  output logic [WIDTH_A-1:0]   coef_addr,
  input  logic [15:0]          coef,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-15){1'b0}}, 16'h7FFF};
  localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W-15){1'b1}}, 16'h8000};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CH_W-1:0] ch;
  logic            in_hs;
  logic            out_hs;
  logic            last_ch;
  logic            start_frame;

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;
  logic [15:0]           sat;
  logic [15:0]           result;

  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign last_ch     = (ch == LAST_CH);
  assign start_frame = (state == IDLE) && start;
  assign coef_addr   = WIDTH_A'(ch);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (in_hs && last_ch) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The counter parks on the last channel once the frame ends, so it never exceeds NUM_CH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch <= '0;
    end else if (start_frame) begin
      ch <= '0;
    end else if (in_hs && !last_ch) begin
      ch <= ch + 1'b1;
    end
  end

  assign sum     = $signed({in_data[ACC_W-1], in_data}) + $signed({{(ACC_W-15){coef[15]}}, coef});
  assign shifted = sum >>> SHIFT;

  always_comb begin
    sat = shifted[15:0];
    if (shifted > SAT_HI) begin
      sat = 16'h7FFF;
    end else if (shifted < SAT_LO) begin
      sat = 16'h8000;
    end
  end

`ifdef FB_BIAS_RELU_EN
  assign result = sat[15] ? 16'h0000 : sat;
`else
  assign result = sat;
`endif

  // A new input reloads the output stage even while the previous result is leaving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
    end else if (in_hs) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_last  <= last_ch;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fb_bias_add.sv
// Self-checking bench for fb_bias_add: directed corner cases plus randomized frames
// scored against an arithmetic reference model of the bias/shift/saturate rule.
module tb_fb_bias_add;

  localparam int NUM_CH = 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [11:0] coef_addr;
  logic [15:0] coef;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] rom [0:4095];
  int assertions = 0;
  int failures   = 0;

  always #5 clk = ~clk;

  assign coef = rom[coef_addr];

  fb_bias_add dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_addr (coef_addr),
    .coef      (coef),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Floor division by 2**SHIFT, then clamp to the signed 16-bit range.
  function automatic logic [15:0] ref_result(input logic [23:0] d, input logic [15:0] c);
    longint s;
    longint q;
    s = longint'($signed(d)) + longint'($signed(c));
    q = s / 16;
    if (s < 0 && (s % 16) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef FB_BIAS_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[15:0];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    assertions++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b, required 0", in_ready); end
    assertions++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b, required 0", out_valid); end
    assertions++; if (out_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_out_data: got %h, required 0000", out_data); end
    assertions++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: got %b, required 0", out_last); end
    assertions++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_done: got %b%b, required 00", busy, done); end
    assertions++; if (coef_addr !== 12'h000) begin failures++; $display("[TB] FAIL reset_coef_addr: got %h, required 000", coef_addr); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 24'h000100; out_ready = 1'b1;
    #1;
    assertions++; if (coef_addr !== 12'd0) begin failures++; $display("[TB] FAIL basic_addr0: got %0d, required 0", coef_addr); end
    assertions++; if (in_ready !== 1'b1 || busy !== 1'b1) begin failures++; $display("[TB] FAIL basic_ready_busy: got %b%b, required 11", in_ready, busy); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL basic_valid: got %b, required 1", out_valid); end
    assertions++; if (out_data !== 16'h0016) begin failures++; $display("[TB] FAIL basic_data: got %h, required 0016", out_data); end
    assertions++; if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL basic_last: got %b, required 0", out_last); end
    assertions++; if (coef_addr !== 12'd1) begin failures++; $display("[TB] FAIL basic_addr1: got %0d, required 1", coef_addr); end
  endtask

  task automatic test_negative();
    logic [15:0] expv;
`ifdef FB_BIAS_RELU_EN
    expv = 16'h0000;
`else
    expv = 16'hFFB0;
`endif
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'hFFFC18;
    #1;
    assertions++; if (coef_addr !== 12'd1) begin failures++; $display("[TB] FAIL neg_addr: got %0d, required 1", coef_addr); end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b1 || out_data !== expv) begin failures++; $display("[TB] FAIL neg_data: got %b/%h, required 1/%h", out_valid, out_data, expv); end
  endtask

  task automatic test_saturation();
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'h7FFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b1 || out_data !== 16'h7FFF) begin failures++; $display("[TB] FAIL sat_pos: got %b/%h, required 1/7fff", out_valid, out_data); end
  endtask

  task automatic test_start_ignored();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    assertions++; if (coef_addr !== 12'd3 || busy !== 1'b1) begin failures++; $display("[TB] FAIL start_in_run: got addr %0d busy %b, required 3 1", coef_addr, busy); end
  endtask

  task automatic test_mid_reset();
    for (int i = 3; i < 57; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 24'($urandom); out_ready = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    assertions++; if (coef_addr !== 12'd57 || out_valid !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset: got addr %0d valid %b, required 57 1", coef_addr, out_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    assertions++; if (out_valid !== 1'b0 || out_data !== 16'h0000 || out_last !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_out: got %b/%h/%b, required 0/0000/0", out_valid, out_data, out_last); end
    assertions++; if (coef_addr !== 12'd0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_ctrl: got addr %0d busy %b done %b rdy %b, required 0 0 0 0", coef_addr, busy, done, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      #1;
      assertions++; if (in_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_idle: got rdy %b busy %b, required 0 0", in_ready, busy); end
    end
    in_valid = 1'b0;
  endtask

  // Random-stall frame engine: scoreboard keyed on the bench's own channel count.
  task automatic run_frames(input int n_frames, output int outs, output int dones, output int lasts);
    logic [16:0] q[$];
    logic [16:0] e;
    int exp_ch;
    int started;
    int cycles;
    bit pend;
    exp_ch = 0; started = 0; cycles = 0; pend = 1'b1;
    outs = 0; dones = 0; lasts = 0;
    while (cycles < 6000 && (started < n_frames || dones < n_frames || q.size() != 0 || out_valid === 1'b1)) begin
      @(negedge clk);
      cycles++;
      start = pend;
      if (pend) begin exp_ch = 0; started++; pend = 1'b0; end
      in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: in_data = 24'h7FFFFF;
        1: in_data = 24'h800000;
        default: in_data = 24'($urandom);
      endcase
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (out_valid && out_ready) begin
        assertions++;
        if (q.size() == 0) begin
          failures++; $display("[TB] FAIL extra_output: got out_data %h, required no output", out_data);
        end else begin
          e = q.pop_front();
          outs++;
          if (out_last) lasts++;
          if ({out_last, out_data} !== e) begin failures++; $display("[TB] FAIL frame_output: got last %b data %h, required last %b data %h", out_last, out_data, e[16], e[15:0]); end
        end
      end
      if (in_valid && in_ready) begin
        assertions++;
        if (coef_addr !== 12'(exp_ch)) begin failures++; $display("[TB] FAIL frame_addr: got %0d, required %0d", coef_addr, exp_ch); end
        q.push_back({exp_ch == NUM_CH - 1, ref_result(in_data, rom[exp_ch % 4096])});
        exp_ch++;
      end
      if (done) begin
        dones++;
        assertions++;
        if (exp_ch != NUM_CH) begin failures++; $display("[TB] FAIL done_timing: got %0d inputs, required %0d", exp_ch, NUM_CH); end
        if (started < n_frames) pend = 1'b1;
      end
    end
    start = 1'b0; in_valid = 1'b0;
    assertions++;
    if (cycles >= 6000) begin failures++; $display("[TB] FAIL frame_timeout: got %0d cycles, required under 6000", cycles); end
  endtask

  task automatic test_full_frame();
    int outs, dones, lasts;
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    run_frames(1, outs, dones, lasts);
    assertions++; if (outs != NUM_CH) begin failures++; $display("[TB] FAIL frame_count: got %0d, required %0d", outs, NUM_CH); end
    assertions++; if (dones != 1 || lasts != 1) begin failures++; $display("[TB] FAIL frame_done_last: got done %0d last %0d, required 1 1", dones, lasts); end
  endtask

  task automatic test_back_to_back();
    int outs, dones, lasts;
    run_frames(2, outs, dones, lasts);
    assertions++; if (outs != 2 * NUM_CH) begin failures++; $display("[TB] FAIL b2b_count: got %0d, required %0d", outs, 2 * NUM_CH); end
    assertions++; if (dones != 2 || lasts != 2) begin failures++; $display("[TB] FAIL b2b_done_last: got done %0d last %0d, required 2 2", dones, lasts); end
    #1;
    assertions++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL b2b_idle: got busy %b, required 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 16'($urandom);
    rom[0] = 16'h0066;
    rom[1] = 16'hFEF4;
    rom[2] = 16'h0066;
    test_reset();
    test_basic();
    test_negative();
    test_saturation();
    test_start_ignored();
    test_mid_reset();
    test_full_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
